mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding the MEM/WB register. It decodes load/store operations from `instr`/`instr_type`, runs a request/acknowledge transaction on the data-memory port, and applies byte-lane steering and sign extension. It stalls the upstream pipeline while a transaction is outstanding and produces one registered write-back record per retired instruction.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in WAIT before the bus-error abort; width 8 bits, legal range 1–255.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: the EX/MEM register holds a live instruction.
- `alu_result` input 32: effective address for memory ops, or the result for non-memory ops.
- `rs2_val` input 32: store data.
- `rd_idx` input 5: destination register.
- `instr` input 32: raw instruction; `funct3 = instr[14:12]`.
- `instr_type` input 4: 4'h1 = LOAD, 4'h2 = STORE, anything else = non-memory.
- `stall_out` output 1: freezes the PC and the IF/ID, ID/EX and EX/MEM registers.
- `dmem_req` output 1: memory request, registered.
- `dmem_we` output 1: 1 = write.
- `dmem_addr` output 32: word address, `{alu_result[31:2],2'b00}`.
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_be` output 4: byte enables.
- `dmem_ack` input 1: transaction complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` input 32: read word.
- `wb_valid` output 1: write-back record valid.
- `wb_we` output 1: register-file write enable.
- `wb_rd_idx` output 5: write-back destination.
- `wb_data` output 32: write-back value.
- `misalign_err` output 1: one-cycle pulse, coincident with `wb_valid`.
- `bus_err` output 1: one-cycle pulse, coincident with `wb_valid`.

## Operation
- FSM states: IDLE and WAIT. Reset enters IDLE.
- **IDLE, `in_valid` = 0:** next cycle `wb_valid` = 0.
- **IDLE, non-memory op:** next cycle `wb_valid` = 1, `wb_we` = (`rd_idx` != 0), `wb_data` = `alu_result`. No stall.
- **IDLE, memory op, aligned and legal:**
  - Register address, `dmem_we`, `dmem_be` and `dmem_wdata`; assert `dmem_req`; go to WAIT.
  - `stall_out` = 1 combinationally in this cycle.
  - Clear the timeout counter.
- **IDLE, memory op, misaligned or illegal funct3:**
  - No memory request.
  - Next cycle: `wb_valid` = 1, `wb_we` = 0, `misalign_err` = 1. No stall.
- **Legal funct3 values:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- **Misalignment:** W with `addr[1:0]` != 0; H/HU with `addr[0]` != 0.
- **Store steering (`a = addr[1:0]`):**
  - B: `be` = 4'b0001 << a, `wdata` = {4{rs2[7:0]}}.
  - H: `be` = 4'b0011 << a, `wdata` = {2{rs2[15:0]}}.
  - W: `be` = 4'b1111, `wdata` = `rs2`.
- **Loads:** `dmem_we` = 0 and `dmem_be` = 4'b1111. The result lane is selected by `addr[1:0]`, captured in WAIT, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- **WAIT:**
  - `dmem_req` and all request fields are held stable until ack.
  - `stall_out` = !`dmem_ack`. The upstream register therefore advances on the same edge that retires the transaction.
  - Counter increments each cycle.
- **WAIT, on `dmem_ack`:**
  - Drop `dmem_req`; go to IDLE.
  - Next cycle: `wb_valid` = 1.
  - Load: `wb_we` = (`rd_idx` != 0), `wb_data` = extracted value.
  - Store: `wb_we` = 0, `wb_data` = 0.
- **WAIT, counter reaches `TIMEOUT_CYCLES` without ack:**
  - Drop `dmem_req`; go to IDLE.
  - Next cycle: `wb_valid` = 1, `wb_we` = 0, `bus_err` = 1.
  - If ack and timeout occur in the same cycle, ack wins.
- **`wb_rd_idx`:** always the registered `rd_idx` of the retiring instruction.
- **`dmem_ack` while in IDLE:** ignored.

## Timing
- **Reset:** asynchronous. Every output is 0 and the FSM is in IDLE, including when reset hits mid-WAIT. `dmem_req` drops immediately; any in-flight ack is discarded.
- **Non-memory and error ops:** 1-cycle latency, no stall.
- **Memory ops:**
  - Op present in IDLE at cycle 0.
  - `dmem_req` is high from cycle 1.
  - Ack arrives in cycle k ≥ 1.
  - `wb_valid` is asserted in cycle k+1.
  - `stall_out` is high in cycles 0..k-1 and low in cycle k.
  - Minimum load-to-write-back time is 2 cycles.
- **Back-to-back memory ops:** the next op is seen in IDLE at cycle k+1, so at most one transaction is ever outstanding.
- **`wb_valid`, `misalign_err`, `bus_err`:** single-cycle pulses per instruction.

## Test plan
- **Non-memory pass-through:** type 4'h0, `alu_result` = 0x1234, rd = 5 -> next cycle `wb_valid` = 1, `wb_we` = 1, `wb_data` = 0x1234, `stall_out` never high. With rd = 0 -> `wb_we` = 0.
- **Load byte, sign-extended:** LB at addr 0x103, rdata = 0x80FF_FF7F with ack after 3 WAIT cycles -> `wb_data` = 0xFFFF_FF80, `stall_out` high for 3 cycles then low in the ack cycle. LBU at the same address -> `wb_data` = 0x0000_0080.
- **Store half-word:** SH at addr 0x202, rs2 = 0xDEAD_BEEF -> `dmem_addr` = 0x200, `be` = 4'b1100, `wdata` = 0xBEEF_BEEF, `we` = 1. On write-back: `wb_valid` = 1, `wb_we` = 0.
- **Misaligned:** LW at addr 0x101 -> `dmem_req` never asserted; `misalign_err` = 1 and `wb_valid` = 1 with `wb_we` = 0 one cycle later.
- **Timeout:** `TIMEOUT_CYCLES` = 4, no ack -> `dmem_req` drops after 4 WAIT cycles, then `bus_err` pulses. Repeat with ack in the same cycle as the timeout -> normal completion, `bus_err` = 0.
- **Reset mid-WAIT:** assert `rst` in the 2nd WAIT cycle -> `dmem_req`, `stall_out` and `wb_valid` drop to 0 immediately. A following LW at 0x0 with ack completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage: load/store bus handshake, lane steering, write-back record
module mem_stage #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_idx,
  input  logic [31:0] instr,
  input  logic [3:0]  instr_type,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_idx,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic [4:0]  r_rd_idx;

  logic [2:0]  w_funct3;
  logic [1:0]  w_a;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_legal;
  logic        w_misalign;
  logic        w_mem_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;
  logic [31:0] w_shifted;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign w_funct3   = instr[14:12];
  assign w_a        = alu_result[1:0];
  assign w_is_load  = (instr_type == 4'h1);
  assign w_is_store = (instr_type == 4'h2);
  assign w_mem_ok   = (w_is_load || w_is_store) && w_legal && !w_misalign;
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_timeout  = (w_cnt_inc == TIMEOUT_CYCLES);

  // Decode funct3 legality, alignment, and store byte-lane steering for the incoming op
  always_comb begin
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = 32'h0;
    if (w_is_load) begin
      w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
    end else if (w_is_store) begin
      w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
    end
    if (w_funct3[1:0] == 2'b10) begin
      w_misalign = (w_a != 2'b00);
    end else if (w_funct3[1:0] == 2'b01) begin
      w_misalign = w_a[0];
    end
    if (w_is_store) begin
      case (w_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{rs2_val[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_a;
          w_wdata = {2{rs2_val[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = rs2_val;
        end
      endcase
    end
  end

  // Select the addressed lane of the read word and extend it per the load width
  always_comb begin
    w_shifted  = dmem_rdata >> {r_addr_lo, 3'b000};
    w_half     = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_shifted[7:0]};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = dmem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and stall: stall launches with the request and releases in the ack cycle
  always_comb begin
    w_state_next = r_state;
    stall_out    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_mem_ok) begin
          w_state_next = S_WAIT;
          stall_out    = 1'b1;
        end
      end
      S_WAIT: begin
        stall_out = !dmem_ack;
        if (dmem_ack || w_timeout) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (rst) stall_out = 1'b0;
  end

  // Request registers, transaction context, timeout counter and the write-back record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_be      <= 4'h0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd_idx    <= 5'h0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      r_cnt        <= 8'h0;
      r_addr_lo    <= 2'b00;
      r_funct3     <= 3'b000;
      r_is_load    <= 1'b0;
      r_rd_idx     <= 5'h0;
    end else begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (!w_is_load && !w_is_store) begin
              wb_valid  <= 1'b1;
              wb_we     <= (rd_idx != 5'd0);
              wb_data   <= alu_result;
              wb_rd_idx <= rd_idx;
            end else if (w_mem_ok) begin
              dmem_req   <= 1'b1;
              dmem_we    <= w_is_store;
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_cnt      <= 8'h0;
              r_addr_lo  <= w_a;
              r_funct3   <= w_funct3;
              r_is_load  <= w_is_load;
              r_rd_idx   <= rd_idx;
            end else begin
              wb_valid     <= 1'b1;
              wb_data      <= 32'h0;
              wb_rd_idx    <= rd_idx;
              misalign_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            wb_valid  <= 1'b1;
            wb_rd_idx <= r_rd_idx;
            wb_we     <= r_is_load && (r_rd_idx != 5'd0);
            wb_data   <= r_is_load ? w_load_val : 32'h0;
          end else if (w_timeout) begin
            dmem_req  <= 1'b0;
            wb_valid  <= 1'b1;
            wb_rd_idx <= r_rd_idx;
            wb_data   <= 32'h0;
            bus_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] rs2_val;
  logic [4:0]  rd_idx;
  logic [31:0] instr;
  logic [3:0]  instr_type;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        bus;
  } wb_rec_t;

  wb_rec_t exp_q[$];

  mem_stage #(.TIMEOUT_CYCLES(8'(TO))) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .rs2_val(rs2_val), .rd_idx(rd_idx), .instr(instr), .instr_type(instr_type),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic we, input logic [31:0] data,
                      input logic chk_data, input logic mis, input logic bus);
    wb_rec_t r;
    r.rd = rd; r.we = we; r.data = data; r.chk_data = chk_data; r.mis = mis; r.bus = bus;
    exp_q.push_back(r);
  endtask

  // Monitor: every write-back pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'h0);
      end else begin
        wb_rec_t e;
        e = exp_q.pop_front();
        chk("wb_rd_idx", 32'(wb_rd_idx), 32'(e.rd));
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("misalign_err", 32'(misalign_err), 32'(e.mis));
        chk("bus_err", 32'(bus_err), 32'(e.bus));
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end else if (!rst && (misalign_err || bus_err)) begin
      chk("err_without_wb", 32'({misalign_err, bus_err}), 32'h0);
    end
  end

  task automatic drive(input logic [3:0] t, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd);
    in_valid   = 1'b1;
    instr_type = t;
    instr      = {17'h0, f3, 5'h0, 7'h03};
    alu_result = addr;
    rs2_val    = rs2;
    rd_idx     = rd;
  endtask

  task automatic simple_op(input logic [3:0] t, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd);
    @(posedge clk); #1;
    drive(t, f3, addr, rs2, rd);
    @(negedge clk);
    chk("stall_simple", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0; instr_type = 4'h0;
    @(negedge clk);
    chk("no_req_simple", 32'(dmem_req), 32'h0);
  endtask

  // k = cycle of ack (1 = first WAIT cycle); k = 0 means never ack
  task automatic mem_op(input logic [3:0] t, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input int k,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    @(posedge clk); #1;
    drive(t, f3, addr, rs2, rd);
    @(negedge clk);
    chk("stall_c0", 32'(stall_out), 32'h1);
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == k) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
      chk("req_held", 32'(dmem_req), 32'h1);
      chk("stall_wait", 32'(stall_out), (cyc == k) ? 32'h0 : 32'h1);
      if (cyc == 1) begin
        chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("dmem_we", 32'(dmem_we), (t == 4'h2) ? 32'h1 : 32'h0);
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        if (t == 4'h2) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (cyc == k || cyc == TO) break;
    end
    in_valid = 1'b0; instr_type = 4'h0;
    @(negedge clk);
    chk("req_drop", 32'(dmem_req), 32'h0);
    chk("stall_after", 32'(stall_out), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_result = 32'h0; rs2_val = 32'h0; rd_idx = 5'h0;
    instr = 32'h0; instr_type = 4'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_errs", 32'({misalign_err, bus_err}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory pass-through
    push(5'd5, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0);
    simple_op(4'h0, 3'b000, 32'h1234, 32'h0, 5'd5);
    push(5'd0, 1'b0, 32'h5678, 1'b1, 1'b0, 1'b0);
    simple_op(4'h7, 3'b000, 32'h5678, 32'h0, 5'd0);

    // Loads with lane selection and extension
    push(5'd7, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b000, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_FF7F, 4'hF, 32'h0);
    push(5'd7, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b100, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_FF7F, 4'hF, 32'h0);
    push(5'd8, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b001, 32'h002, 32'h0, 5'd8, 1, 32'h8001_1234, 4'hF, 32'h0);
    push(5'd8, 1'b1, 32'h0000_F00D, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b101, 32'h000, 32'h0, 5'd8, 2, 32'h0000_F00D, 4'hF, 32'h0);
    push(5'd0, 1'b0, 32'h0000_007F, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b000, 32'h000, 32'h0, 5'd0, 1, 32'h0000_007F, 4'hF, 32'h0);

    // Stores with byte-lane steering
    push(5'd9, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    mem_op(4'h2, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd9, 2, 32'h0, 4'b1100, 32'hBEEF_BEEF);
    push(5'd9, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    mem_op(4'h2, 3'b000, 32'h001, 32'h1234_56AB, 5'd9, 1, 32'h0, 4'b0010, 32'hABAB_ABAB);
    push(5'd9, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    mem_op(4'h2, 3'b010, 32'h300, 32'hA5A5_0F0F, 5'd9, 1, 32'h0, 4'b1111, 32'hA5A5_0F0F);

    // Misaligned and illegal funct3
    push(5'd6, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    simple_op(4'h1, 3'b010, 32'h101, 32'h0, 5'd6);
    push(5'd6, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    simple_op(4'h1, 3'b001, 32'h103, 32'h0, 5'd6);
    push(5'd4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    simple_op(4'h1, 3'b011, 32'h000, 32'h0, 5'd4);
    push(5'd4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    simple_op(4'h2, 3'b100, 32'h000, 32'h0, 5'd4);

    // Timeout with no ack, then ack coincident with timeout
    push(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    mem_op(4'h1, 3'b010, 32'h040, 32'h0, 5'd11, 0, 32'h0, 4'hF, 32'h0);
    push(5'd12, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b010, 32'h044, 32'h0, 5'd12, TO, 32'h1122_3344, 4'hF, 32'h0);

    // Ack while idle is ignored
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", 32'(wb_valid), 32'h0);

    // Reset in the second WAIT cycle, with an ack in flight
    @(posedge clk); #1;
    drive(4'h1, 3'b010, 32'h080, 32'h0, 5'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_req_before", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    chk("rstmid_req", 32'(dmem_req), 32'h0);
    chk("rstmid_stall", 32'(stall_out), 32'h0);
    chk("rstmid_wb_valid", 32'(wb_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b0; in_valid = 1'b0; instr_type = 4'h0;
    @(negedge clk);
    chk("rstmid_after_req", 32'(dmem_req), 32'h0);
    chk("rstmid_after_wb", 32'(wb_valid), 32'h0);
    push(5'd3, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    mem_op(4'h1, 3'b010, 32'h000, 32'h0, 5'd3, 2, 32'hCAFE_F00D, 4'hF, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
